// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM and hands each {note, duration} entry to the
// note player. It issues a one-cycle load pulse, then waits for the player's
// done_with_note before it fetches the next entry.
module song_sequencer #(
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned IDX_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic             start,
    input  logic [1:0]       song_select,
    output logic [IDX_W+1:0] rom_addr,
    input  logic [11:0]      rom_data,
    output logic [5:0]       note_to_load,
    output logic [5:0]       duration_to_load,
    output logic             load_new_note,
    input  logic             done_with_note,
    output logic             song_done,
    output logic [IDX_W-1:0] note_index
);

    // The holdoff counter runs from 0 to HOLDOFF-1 while in StHold.
    localparam int unsigned CntW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned HoldLastInt = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;
    localparam logic [CntW-1:0] HoldLast = HoldLastInt[CntW-1:0];

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StLoad,
        StHold,
        StWaitDone,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        song_q, song_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W+1:0]  rom_addr_q, rom_addr_d;
    logic [5:0]        note_q, note_d;
    logic [5:0]        dur_q, dur_d;

    // Next-state logic, datapath updates and Moore outputs.
    always_comb begin
        state_d       = state_q;
        song_d        = song_q;
        index_d       = index_q;
        hold_cnt_d    = hold_cnt_q;
        rom_addr_d    = rom_addr_q;
        note_d        = note_q;
        dur_d         = dur_q;
        load_new_note = 1'b0;
        song_done     = 1'b0;

        if (start) begin
            // start overrides every state; a pending load pulse is suppressed.
            song_d  = song_select;
            index_d = '0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StFetch: begin
                    state_d = StDecode;
                end
                StDecode: begin
                    // Duration 0 marks end of song; the outputs keep the last note.
                    if (rom_data[5:0] == 6'd0) begin
                        state_d = StDone;
                    end else begin
                        note_d  = rom_data[11:6];
                        dur_d   = rom_data[5:0];
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    load_new_note = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = (HOLDOFF == 0) ? StWaitDone : StHold;
                end
                StHold: begin
                    // done_with_note may still reflect the previous note here.
                    if (hold_cnt_q == HoldLast) begin
                        state_d = StWaitDone;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (done_with_note && play) begin
                        if (&index_q) begin
                            state_d = StDone;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                StDone: begin
                    song_done = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // The address is updated only when FETCH is entered.
        if (state_d == StFetch) begin
            rom_addr_d = {song_d, index_d};
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            song_q     <= '0;
            index_q    <= '0;
            hold_cnt_q <= '0;
            rom_addr_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            index_q    <= index_d;
            hold_cnt_q <= hold_cnt_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign note_index       = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: a synchronous ROM model with random songs and a
// song-level reference model (entries up to the first zero duration or slot 31).
module tb_song_sequencer;

    localparam int unsigned IdxW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            play;
    logic            start;
    logic [1:0]      song_select;
    logic [IdxW+1:0] rom_addr;
    logic [11:0]     rom_data;
    logic [5:0]      note_to_load;
    logic [5:0]      duration_to_load;
    logic            load_new_note;
    logic            done_with_note;
    logic            song_done;
    logic [IdxW-1:0] note_index;

    int n_assert   = 0;
    int n_fail     = 0;
    int load_count = 0;

    logic [11:0] rom [0:127];

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    song_sequencer #(
        .HOLDOFF(2),
        .IDX_W  (IdxW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .play            (play),
        .start           (start),
        .song_select     (song_select),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .note_to_load    (note_to_load),
        .duration_to_load(duration_to_load),
        .load_new_note   (load_new_note),
        .done_with_note  (done_with_note),
        .song_done       (song_done),
        .note_index      (note_index)
    );

    // Advance one cycle; outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (load_new_note) load_count++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: number of playable entries in a song.
    function automatic int song_len(input int s);
        int n = 0;
        while (n < 32 && rom[s * 32 + n][5:0] != 6'd0) n++;
        return n;
    endfunction

    function automatic logic [5:0] exp_note(input int s, input int i);
        logic [11:0] e;
        e = rom[s * 32 + i];
        return e[11:6];
    endfunction

    function automatic logic [5:0] exp_dur(input int s, input int i);
        logic [11:0] e;
        e = rom[s * 32 + i];
        return e[5:0];
    endfunction

    // Plays song s with random player delays; returns early at the load of stop_idx.
    task automatic run_song(input int s, input int stop_idx, input bit do_pause);
        int n;
        int base;
        int k;
        n    = song_len(s);
        base = load_count;
        song_select = s[1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_addr", rom_addr, s * 32);
        check("start_noload1", load_new_note, 0);
        tick();
        check("start_noload2", load_new_note, 0);
        tick();
        for (int i = 0; i < n; i++) begin
            check("load_pulse", load_new_note, 1);
            check("load_note", note_to_load, exp_note(s, i));
            check("load_dur", duration_to_load, exp_dur(s, i));
            check("load_index", note_index, i);
            if (i == stop_idx) return;
            k = $urandom_range(3, 8);
            repeat (k) begin
                tick();
                check("gap_noload", load_new_note, 0);
            end
            if (do_pause && i == 1) begin
                play = 1'b0;
                done_with_note = 1'b1;
                repeat (20) begin
                    tick();
                    check("pause_noload", load_new_note, 0);
                    check("pause_index", note_index, i);
                end
                play = 1'b1;
            end
            done_with_note = 1'b1;
            tick();
            done_with_note = 1'b0;
            if (i < n - 1) begin
                check("turn_noload1", load_new_note, 0);
                tick();
                check("turn_noload2", load_new_note, 0);
                tick();
            end else if (n == 32) begin
                check("full_done", song_done, 1);
                check("full_index", note_index, 31);
            end else begin
                check("end_noload1", load_new_note, 0);
                tick();
                check("end_noload2", load_new_note, 0);
                tick();
                check("end_done", song_done, 1);
                check("end_index", note_index, n);
            end
        end
        repeat (5) begin
            tick();
            check("done_noload", load_new_note, 0);
            check("done_hold", song_done, 1);
        end
        check("load_total", load_count - base, n);
    endtask

    initial begin
        int m;
        int base;
        logic [5:0] old_note;

        reset = 1'b1;
        play = 1'b0;
        start = 1'b0;
        song_select = 2'd0;
        done_with_note = 1'b0;

        for (int a = 0; a < 128; a++) begin
            rom[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        end
        m = $urandom_range(8, 20);
        rom[m][5:0] = 6'd0;
        rom[32] = {6'd12, 6'd4};
        rom[33] = {6'd20, 6'd8};
        rom[34] = {6'd7, 6'd0};
        m = $urandom_range(2, 10);
        rom[64 + m][5:0] = 6'd0;
        rom[64][11:6] = 6'd0;

        // Reset state and idle behaviour.
        repeat (3) tick();
        reset = 1'b0;
        check("rst_addr", rom_addr, 0);
        check("rst_note", note_to_load, 0);
        check("rst_dur", duration_to_load, 0);
        check("rst_load", load_new_note, 0);
        check("rst_done", song_done, 0);
        check("rst_index", note_index, 0);
        repeat (5) tick();
        check("idle_noload", load_count, 0);

        // Basic two-note song.
        play = 1'b1;
        base = load_count;
        song_select = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_addr", rom_addr, 7'h20);
        tick();
        tick();
        check("basic_load0", load_new_note, 1);
        check("basic_note0", note_to_load, 12);
        check("basic_dur0", duration_to_load, 4);
        repeat (10) tick();
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        tick();
        tick();
        check("basic_load1", load_new_note, 1);
        check("basic_note1", note_to_load, 20);
        check("basic_dur1", duration_to_load, 8);
        repeat (5) tick();
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        tick();
        tick();
        check("basic_done", song_done, 1);
        check("basic_index", note_index, 2);
        check("basic_keep_note", note_to_load, 20);
        check("basic_keep_dur", duration_to_load, 8);
        check("basic_loads", load_count - base, 2);

        // Holdoff: done held high through the load.
        done_with_note = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("hold_load0", load_new_note, 1);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("hold_noload", load_new_note, 0);
        end
        tick();
        check("hold_load1", load_new_note, 1);
        check("hold_note1", note_to_load, 20);
        done_with_note = 1'b0;

        // Random song 0 up to index 5, then restart into song 2 during a load.
        run_song(0, 5, 1'b0);
        old_note = note_to_load;
        song_select = 2'd2;
        start = 1'b1;
        #1;
        check("restart_drop", load_new_note, 0);
        check("restart_done0", song_done, 0);
        tick();
        start = 1'b0;
        check("restart_addr", rom_addr, 7'h40);
        check("restart_done1", song_done, 0);
        check("restart_keep", note_to_load, old_note);
        tick();
        tick();
        check("restart_load", load_new_note, 1);
        check("restart_rest", note_to_load, 0);

        // Random songs with a pause; song 3 uses all 32 slots.
        run_song(2, -1, 1'b1);
        run_song(3, -1, 1'b1);
        song_select = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_done", song_done, 0);
        check("clear_addr", rom_addr, 7'h60);

        // Reset mid-song aborts without further loads.
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_addr", rom_addr, 0);
        check("mrst_note", note_to_load, 0);
        check("mrst_index", note_index, 0);
        check("mrst_done", song_done, 0);
        base = load_count;
        done_with_note = 1'b1;
        repeat (10) tick();
        done_with_note = 1'b0;
        check("mrst_noload", load_count - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
